// File: rtl/mem_bus_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_pkg
// Purpose  : Shared types, widths and helpers for the memory bus responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_bus_pkg;

  localparam int DATA_W = 32;
  localparam int BE_W   = 4;

  // Fibonacci LFSR for randomised wait lengths: taps 8,6,5,4 map to bits 7,5,4,3.
  localparam logic [7:0] LFSR_SEED = 8'hA5;
  localparam logic [7:0] LFSR_TAPS = 8'b1011_1000;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    DONE = 2'd2
  } mem_resp_state_t;

  // Word offset from the window base; addresses below base wrap to huge values.
  function automatic logic [29:0] mem_word_addr(input logic [31:0] addr,
                                                input logic [31:0] base);
    return 30'((addr - base) >> 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/mem_byte_ram.sv
`default_nettype none
// ============================================================================
// Module   : mem_byte_ram
// Purpose  : Word-organised RAM, byte-lane synchronous write, async read.
// Revision : 1.0 - initial release
// ============================================================================
module mem_byte_ram
  import mem_bus_pkg::*;
#(
  parameter int ADDR_W = 10
) (
  input  logic              clk,
  input  logic              i_we,
  input  logic [ADDR_W-1:0] i_waddr,
  input  logic [DATA_W-1:0] i_wdata,
  input  logic [BE_W-1:0]   i_be,
  input  logic [ADDR_W-1:0] i_raddr,
  output logic [DATA_W-1:0] o_rdata
);

  logic [DATA_W-1:0] r_mem [2**ADDR_W];

  always_ff @(posedge clk) begin
    if (i_we) begin
      for (int i = 0; i < BE_W; i++) begin
        if (i_be[i]) r_mem[i_waddr][8*i +: 8] <= i_wdata[8*i +: 8];
      end
    end
  end

  assign o_rdata = r_mem[i_raddr];

endmodule
`default_nettype wire

// File: rtl/mem_bus_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_responder
// Purpose  : Avalon-style memory responder with programmable waitrequest.
//            Optional random wait stretch: define MEM_BUS_RAND_WAIT_EN.
// Revision : 1.0 - initial release
// ============================================================================
module mem_bus_responder
  import mem_bus_pkg::*;
#(
  parameter int          ADDR_W      = 10,
  parameter logic [31:0] BASE_ADDR   = 32'hBFC0_0000,
  parameter int          WAIT_CYCLES = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [31:0]       address,
  input  logic              read,
  input  logic              write,
  input  logic [DATA_W-1:0] writedata,
  input  logic [BE_W-1:0]   byteenable,
  output logic              waitrequest,
  output logic [DATA_W-1:0] readdata
);

  localparam int             CNT_W       = 5;
  localparam logic [CNT_W-1:0] c_load_base = CNT_W'(WAIT_CYCLES - 1);

  mem_resp_state_t   r_state, w_state_nxt;
  logic [CNT_W-1:0]  r_cnt, w_load;
  logic [ADDR_W-1:0] r_idx, w_raddr;
  logic [DATA_W-1:0] r_wdata, r_readdata, w_ram_rdata, w_rd_value;
  logic [BE_W-1:0]   r_be;
  logic              r_rd_ok, r_wr_ok;
  logic              w_req, w_live_in_range, w_sel_read, w_capture_rd, w_ram_we, w_wait;
  logic [29:0]       w_word;

  assign w_req           = read | write;
  assign w_word          = mem_word_addr(address, BASE_ADDR);
  assign w_live_in_range = (w_word[29:ADDR_W] == '0);

`ifdef MEM_BUS_RAND_WAIT_EN
  logic [7:0] r_lfsr;

  always_ff @(posedge clk) begin
    if (reset) r_lfsr <= LFSR_SEED;
    else       r_lfsr <= {r_lfsr[6:0], ^(r_lfsr & LFSR_TAPS)};
  end

  assign w_load = c_load_base + {{(CNT_W-2){1'b0}}, r_lfsr[1:0]};
`else
  assign w_load = c_load_base;
`endif

  // In IDLE the RAM is addressed from the live bus so a one-cycle wait can complete directly.
  assign w_raddr    = (r_state == IDLE) ? w_word[ADDR_W-1:0] : r_idx;
  assign w_sel_read = (r_state == IDLE) ? (read & ~write & w_live_in_range) : r_rd_ok;
  assign w_rd_value = w_sel_read ? w_ram_rdata : '0;
  assign w_ram_we   = (r_state == DONE) & r_wr_ok & ~reset;

  always_comb begin
    w_state_nxt  = r_state;
    w_wait       = 1'b0;
    w_capture_rd = 1'b0;
    case (r_state)
      IDLE: begin
        w_wait = w_req;
        if (w_req) begin
          w_state_nxt  = (w_load == '0) ? DONE : WAIT;
          w_capture_rd = (w_load == '0);
        end
      end
      WAIT: begin
        w_wait = w_req;
        if (!w_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt <= CNT_W'(1)) begin
          w_state_nxt  = DONE;
          w_capture_rd = 1'b1;
        end
      end
      DONE:    w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state    <= IDLE;
      r_cnt      <= '0;
      r_readdata <= '0;
      r_idx      <= '0;
      r_wdata    <= '0;
      r_be       <= '0;
      r_rd_ok    <= 1'b0;
      r_wr_ok    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      if (r_state == IDLE && w_req) begin
        r_cnt   <= w_load;
        r_idx   <= w_word[ADDR_W-1:0];
        r_wdata <= writedata;
        r_be    <= byteenable;
        r_rd_ok <= read & ~write & w_live_in_range;
        r_wr_ok <= write & w_live_in_range;
      end else if (r_state == WAIT && r_cnt != '0) begin
        r_cnt <= r_cnt - 1'b1;
      end
      if (w_capture_rd) r_readdata <= w_rd_value;
    end
  end

  mem_byte_ram #(
    .ADDR_W (ADDR_W)
  ) u_ram (
    .clk     (clk),
    .i_we    (w_ram_we),
    .i_waddr (r_idx),
    .i_wdata (r_wdata),
    .i_be    (r_be),
    .i_raddr (w_raddr),
    .o_rdata (w_ram_rdata)
  );

  assign waitrequest = w_wait;
  assign readdata    = r_readdata;

endmodule
`default_nettype wire

// File: tb/tb_mem_bus_responder.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_mem_bus_responder
// Purpose  : Directed plus randomised bench for mem_bus_responder.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mem_bus_responder;

  localparam logic [31:0] BASE  = 32'hBFC0_0000;
  localparam int          WAITC = 2;

  logic        clk = 1'b0;
  logic        reset, read, write, waitrequest;
  logic [31:0] address, writedata, readdata;
  logic [3:0]  byteenable;

  int          vectors     = 0;
  int          miscompares = 0;
  logic [31:0] model_mem [16];
  bit          seen [4];

  mem_bus_responder #(
    .ADDR_W      (10),
    .BASE_ADDR   (BASE),
    .WAIT_CYCLES (WAITC)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .address     (address),
    .read        (read),
    .write       (write),
    .writedata   (writedata),
    .byteenable  (byteenable),
    .waitrequest (waitrequest),
    .readdata    (readdata)
  );

  always #5 clk = ~clk;

  initial begin
    #1ms;
    $display("FAIL watchdog: observed no finish, expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic check_waits(input string tag, input int w);
`ifdef MEM_BUS_RAND_WAIT_EN
    check(tag, 32'(w >= WAITC && w <= WAITC + 3), 32'd1);
    if (w >= WAITC && w <= WAITC + 3) seen[w - WAITC] = 1'b1;
`else
    check(tag, 32'(w), 32'(WAITC));
`endif
  endtask

  // Reference: window of 1024 words at BASE, only the first 16 are exercised.
  function automatic logic [31:0] exp_read(input logic [31:0] a);
    logic [31:0] d;
    d = a - BASE;
    if (d >= 32'd4096) return 32'h0;
    return model_mem[d[5:2]];
  endfunction

  task automatic model_write(input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    logic [31:0] d;
    d = a - BASE;
    if (d < 32'd64)
      for (int i = 0; i < 4; i++)
        if (be[i]) model_mem[d[5:2]][8*i +: 8] = wd[8*i +: 8];
  endtask

  // Entered and left at posedge+1 with the request lines idle.
  task automatic xfer(input logic rd, input logic wr, input logic [31:0] a,
                      input logic [31:0] wd, input logic [3:0] be,
                      output int waits, output logic [31:0] rdo, output bit ok);
    read = rd; write = wr; address = a; writedata = wd; byteenable = be;
    waits = 0; ok = 1'b0; rdo = '0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!waitrequest) begin
        rdo = readdata;
        ok  = 1'b1;
        break;
      end
      waits++;
      @(posedge clk); #1;
    end
    @(posedge clk); #1;
    read = 1'b0; write = 1'b0;
  endtask

  task automatic do_write(input string tag, input logic [31:0] a, input logic [31:0] wd, input logic [3:0] be);
    int w; logic [31:0] r; bit ok;
    xfer(1'b0, 1'b1, a, wd, be, w, r, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check_waits({tag, "_waits"}, w);
    model_write(a, wd, be);
  endtask

  task automatic do_read(input string tag, input logic [31:0] a, output logic [31:0] r);
    int w; bit ok;
    xfer(1'b1, 1'b0, a, 32'h0, 4'h0, w, r, ok);
    check({tag, "_done"}, 32'(ok), 32'd1);
    check_waits({tag, "_waits"}, w);
    check({tag, "_data"}, r, exp_read(a));
  endtask

  initial begin
    int w; bit ok; logic [31:0] r, a, wd;

    reset = 1'b1; read = 1'b0; write = 1'b0;
    address = '0; writedata = '0; byteenable = '0;
    repeat (3) @(posedge clk);
    #1 reset = 1'b0;
    @(negedge clk);
    check("rst_readdata", readdata, 32'h0);
    check("rst_waitreq", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;

    // Preload and read word 0
    do_write("preload0", BASE, 32'h2402_0005, 4'hF);
    do_read("read0", BASE, r);
    check("read0_const", r, 32'h2402_0005);

    // Byte-lane write merge
    do_write("clr2", BASE + 32'd8, 32'h0, 4'hF);
    do_write("be0101", BASE + 32'd8, 32'hDEAD_BEEF, 4'b0101);
    do_read("read2", BASE + 32'd8, r);
    check("read2_const", r, 32'h00AD_00EF);

    // Out-of-range window
    do_read("below_base", BASE - 32'd4, r);
    do_read("above_top", BASE + 32'd4096, r);
    do_write("wr_above", BASE + 32'd4096, 32'hFFFF_FFFF, 4'hF);
    do_read("after_oor_wr", BASE, r);
    check("after_oor_const", r, 32'h2402_0005);

    // Read and write together behave as a write, readdata 0
    xfer(1'b1, 1'b1, BASE + 32'd12, 32'h55AA_55AA, 4'hF, w, r, ok);
    check("rw_done", 32'(ok), 32'd1);
    check("rw_readdata", r, 32'h0);
    model_write(BASE + 32'd12, 32'h55AA_55AA, 4'hF);
    do_read("read3", BASE + 32'd12, r);

    // Empty byteenable changes nothing
    do_write("be0000", BASE, 32'hFFFF_FFFF, 4'b0000);
    do_read("after_be0", BASE, r);

    // Abort a write after one wait cycle
    do_write("set1", BASE + 32'd4, 32'h1111_1111, 4'hF);
    do_read("read1", BASE + 32'd4, r);
    write = 1'b1; address = BASE + 32'd4; writedata = 32'hCAFE_F00D; byteenable = 4'hF;
    @(negedge clk);
    check("abort_wr_hi", 32'(waitrequest), 32'd1);
    @(posedge clk); #1 write = 1'b0;
    @(negedge clk);
    check("abort_wr_lo", 32'(waitrequest), 32'd0);
    check("abort_rd_hold", readdata, 32'h1111_1111);
    @(posedge clk); #1;
    do_read("after_abort", BASE + 32'd4, r);

    // Reset during DONE of a write suppresses it
    write = 1'b1; address = BASE; writedata = 32'h1234_5678; byteenable = 4'hF;
    ok = 1'b0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (!waitrequest) begin ok = 1'b1; break; end
      @(posedge clk); #1;
    end
    check("rstdone_reach", 32'(ok), 32'd1);
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0; write = 1'b0;
    @(negedge clk);
    check("rstdone_readdata", readdata, 32'h0);
    check("rstdone_waitreq", 32'(waitrequest), 32'd0);
    @(posedge clk); #1;
    do_read("after_rstdone", BASE, r);
    check("after_rstdone_const", r, 32'h2402_0005);

    // Randomised traffic against the model
    for (int i = 0; i < 16; i++) do_write("fill", BASE + 32'(4 * i), $urandom, 4'hF);
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 9) == 0) begin
        if ($urandom_range(0, 1) == 0) a = BASE + 32'd4096 + ($urandom & 32'h0000_0FFF);
        else                           a = BASE - 32'(4 * (1 + $urandom_range(0, 100)));
      end else begin
        a = BASE + 32'(4 * $urandom_range(0, 15)) + 32'($urandom_range(0, 3));
      end
      if (i % 4 == 0) begin
        wd = $urandom;
        do_write("rnd_wr", a, wd, 4'($urandom_range(0, 15)));
      end
      do_read("rnd_rd", a, r);
    end

`ifdef MEM_BUS_RAND_WAIT_EN
    for (int i = 0; i < 4; i++) check("wait_len_seen", 32'(seen[i]), 32'd1);
`endif

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
`default_nettype wire
